issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl.sv | 141 ++++++++++++++
 tb/tb_issue_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// In-order dual-issue control with a register scoreboard.
// Accepts decode slots against busy registers, busy units and intra-pair conflicts.
module issue_ctrl #(
   parameter int FRONTEND_WIDTH = 2,
   parameter int NB_UNIT        = 6,
   parameter int NB_REGS        = 5
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [FRONTEND_WIDTH-1:0]         dec_valid_i,
   input  logic [FRONTEND_WIDTH*NB_UNIT-1:0] dec_unit_i,
   input  logic [FRONTEND_WIDTH*NB_REGS-1:0] dec_rs1_i,
   input  logic [FRONTEND_WIDTH*NB_REGS-1:0] dec_rs2_i,
   input  logic [FRONTEND_WIDTH*NB_REGS-1:0] dec_rd_i,
   input  logic [FRONTEND_WIDTH-1:0]         dec_rs1_v_i,
   input  logic [FRONTEND_WIDTH-1:0]         dec_rs2_v_i,
   input  logic [FRONTEND_WIDTH-1:0]         dec_rd_v_i,
   output logic [FRONTEND_WIDTH-1:0]         dec_accept_o,
   input  logic [NB_UNIT-1:0]                unit_busy_i,
   input  logic [1:0]                        wb_valid_i,
   input  logic [2*NB_REGS-1:0]              wb_rd_i,
   input  logic                              flush_i,
   output logic [FRONTEND_WIDTH-1:0]         iss_valid_o,
   output logic [FRONTEND_WIDTH*NB_UNIT-1:0] iss_unit_o,
   output logic [FRONTEND_WIDTH*NB_REGS-1:0] iss_rd_o,
   output logic [31:0]                       sb_stall_cnt_o
);

   localparam int FW = FRONTEND_WIDTH;
   localparam logic [NB_UNIT-1:0] ALU_M = NB_UNIT'(1);

   logic [NB_UNIT-1:0] unit_w [FW];
   logic [NB_REGS-1:0] rs1_w  [FW];
   logic [NB_REGS-1:0] rs2_w  [FW];
   logic [NB_REGS-1:0] rd_w   [FW];
   logic [FW-1:0]      hz;
   logic [FW-1:0]      ubusy;
   logic [FW-1:0]      acc;

   logic [31:0] busy_q, busy_d;
   logic [31:0] wb_clr, eff_busy;
   logic [FW-1:0]         iss_valid_q, iss_valid_d;
   logic [FW*NB_UNIT-1:0] iss_unit_q, iss_unit_d;
   logic [FW*NB_REGS-1:0] iss_rd_q, iss_rd_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic        chain_ok;
   logic        pair_blk;

   for (genvar g = 0; g < FW; g++) begin : g_slot
      assign unit_w[g] = dec_unit_i[g*NB_UNIT +: NB_UNIT];
      assign rs1_w[g]  = dec_rs1_i[g*NB_REGS +: NB_REGS];
      assign rs2_w[g]  = dec_rs2_i[g*NB_REGS +: NB_REGS];
      assign rd_w[g]   = dec_rd_i[g*NB_REGS +: NB_REGS];
      assign hz[g] = (dec_rs1_v_i[g] & eff_busy[rs1_w[g]])
                   | (dec_rs2_v_i[g] & eff_busy[rs2_w[g]])
                   | (dec_rd_v_i[g]  & eff_busy[rd_w[g]]);
      assign ubusy[g] = |(unit_w[g] & unit_busy_i);
   end

   // Same-cycle writebacks release their registers before hazard checks
   always_comb begin
      wb_clr = '0;
      for (int p = 0; p < 2; p++)
         if (wb_valid_i[p])
            wb_clr[wb_rd_i[p*NB_REGS +: NB_REGS]] = 1'b1;
   end

   assign eff_busy = busy_q & ~wb_clr;

   // In-order accept chain with intra-group RAW/WAW and unit conflicts
   always_comb begin
      acc      = '0;
      chain_ok = ~rst & ~flush_i;
      pair_blk = 1'b0;
      for (int i = 0; i < FW; i++) begin
         pair_blk = 1'b0;
         for (int j = 0; j < i; j++) begin
            if (dec_rd_v_i[j] && rd_w[j] != '0 &&
                ((dec_rs1_v_i[i] && rs1_w[i] == rd_w[j]) ||
                 (dec_rs2_v_i[i] && rs2_w[i] == rd_w[j]) ||
                 (dec_rd_v_i[i]  && rd_w[i]  == rd_w[j])))
               pair_blk = 1'b1;
            if (|(unit_w[i] & unit_w[j] & ~ALU_M))
               pair_blk = 1'b1;
         end
         chain_ok = chain_ok & dec_valid_i[i] & ~hz[i]
                  & ~ubusy[i] & ~pair_blk;
         acc[i] = chain_ok;
      end
   end

   // Scoreboard next state: clear on writeback, set on accept, flush wipes
   always_comb begin
      busy_d = eff_busy;
      for (int i = 0; i < FW; i++)
         if (acc[i] && dec_rd_v_i[i])
            busy_d[rd_w[i]] = 1'b1;
      busy_d[0] = 1'b0;
      if (flush_i)
         busy_d = '0;
   end

   // Issue registers capture accepted slots, stall counter saturates
   always_comb begin
      iss_valid_d = acc;
      iss_unit_d  = iss_unit_q;
      iss_rd_d    = iss_rd_q;
      for (int i = 0; i < FW; i++)
         if (acc[i]) begin
            iss_unit_d[i*NB_UNIT +: NB_UNIT] = unit_w[i];
            iss_rd_d[i*NB_REGS +: NB_REGS]   = rd_w[i];
         end
      stall_cnt_d = stall_cnt_q;
      if (dec_valid_i[0] && hz[0] && !flush_i && stall_cnt_q != '1)
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q      <= '0;
         iss_valid_q <= '0;
         iss_unit_q  <= '0;
         iss_rd_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         busy_q      <= busy_d;
         iss_valid_q <= iss_valid_d;
         iss_unit_q  <= iss_unit_d;
         iss_rd_q    <= iss_rd_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign dec_accept_o   = acc;
   assign iss_valid_o    = iss_valid_q;
   assign iss_unit_o     = iss_unit_q;
   assign iss_rd_o       = iss_rd_q;
   assign sb_stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios then random traffic
// checked against an in-order issue model with a register set.
module tb_issue_ctrl;

   typedef struct {
      bit       v;
      bit [5:0] unit;
      bit [4:0] rd, rs1, rs2;
      bit       rdv, r1v, r2v;
   } slot_t;

   localparam bit [5:0] ALU = 6'b000001;
   localparam bit [5:0] LSU = 6'b001000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   slot_t    s [2];
   bit [1:0] wbv;
   bit [4:0] wbr [2];
   bit [5:0] ubusy;
   bit       fl;

   logic [1:0]  dec_valid_i, dec_accept_o, iss_valid_o;
   logic [11:0] dec_unit_i, iss_unit_o;
   logic [9:0]  dec_rs1_i, dec_rs2_i, dec_rd_i, iss_rd_o, wb_rd_i;
   logic [1:0]  dec_rs1_v_i, dec_rs2_v_i, dec_rd_v_i, wb_valid_i;
   logic [5:0]  unit_busy_i;
   logic        flush_i;
   logic [31:0] sb_stall_cnt_o;

   assign dec_valid_i = {s[1].v, s[0].v};
   assign dec_unit_i  = {s[1].unit, s[0].unit};
   assign dec_rs1_i   = {s[1].rs1, s[0].rs1};
   assign dec_rs2_i   = {s[1].rs2, s[0].rs2};
   assign dec_rd_i    = {s[1].rd, s[0].rd};
   assign dec_rs1_v_i = {s[1].r1v, s[0].r1v};
   assign dec_rs2_v_i = {s[1].r2v, s[0].r2v};
   assign dec_rd_v_i  = {s[1].rdv, s[0].rdv};
   assign unit_busy_i = ubusy;
   assign wb_valid_i  = wbv;
   assign wb_rd_i     = {wbr[1], wbr[0]};
   assign flush_i     = fl;

   issue_ctrl dut (
      .clk(clk), .rst(rst),
      .dec_valid_i(dec_valid_i), .dec_unit_i(dec_unit_i),
      .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i),
      .dec_rs1_v_i(dec_rs1_v_i), .dec_rs2_v_i(dec_rs2_v_i),
      .dec_rd_v_i(dec_rd_v_i), .dec_accept_o(dec_accept_o),
      .unit_busy_i(unit_busy_i), .wb_valid_i(wb_valid_i),
      .wb_rd_i(wb_rd_i), .flush_i(flush_i),
      .iss_valid_o(iss_valid_o), .iss_unit_o(iss_unit_o),
      .iss_rd_o(iss_rd_o), .sb_stall_cnt_o(sb_stall_cnt_o)
   );

   // reference model state
   bit        mb [32];
   bit [31:0] mcnt;
   bit [1:0]  miv;
   bit [5:0]  mu [2];
   bit [4:0]  mr [2];

   int checks = 0;
   int failures = 0;
   logic [1:0] last_acc;
   bit [31:0]  c0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit [31:0] mbv();
      bit [31:0] v = '0;
      for (int r = 0; r < 32; r++) v[r] = mb[r];
      return v;
   endfunction

   function automatic bit wbhit(bit [4:0] r);
      for (int p = 0; p < 2; p++)
         if (wbv[p] && wbr[p] == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit pend(bit [4:0] r, bit used);
      return used && mb[r] && !wbhit(r);
   endfunction

   function automatic bit m_hz(int i);
      return pend(s[i].rs1, s[i].r1v) || pend(s[i].rs2, s[i].r2v)
          || pend(s[i].rd, s[i].rdv);
   endfunction

   // issue oldest-first; stop at the first slot that cannot go
   function automatic bit [1:0] m_accept();
      bit [1:0]  a = '0;
      bit [31:0] claimed = '0;
      bit [5:0]  used = '0;
      if (rst || fl) return 2'b00;
      for (int i = 0; i < 2; i++) begin
         if (!s[i].v || m_hz(i) || (s[i].unit & ubusy) != 0) break;
         if ((s[i].r1v && claimed[s[i].rs1]) ||
             (s[i].r2v && claimed[s[i].rs2]) ||
             (s[i].rdv && claimed[s[i].rd])) break;
         if ((s[i].unit & used & ~ALU) != 0) break;
         a[i] = 1'b1;
         if (s[i].rdv && s[i].rd != 0) claimed[s[i].rd] = 1'b1;
         used |= s[i].unit;
      end
      return a;
   endfunction

   task automatic m_update(bit [1:0] a);
      if (rst) begin
         foreach (mb[r]) mb[r] = 1'b0;
         mcnt = 0; miv = 0;
         mu[0] = 0; mu[1] = 0; mr[0] = 0; mr[1] = 0;
         return;
      end
      if (!fl && s[0].v && m_hz(0) && mcnt != 32'hFFFF_FFFF)
         mcnt++;
      for (int p = 0; p < 2; p++)
         if (wbv[p]) mb[wbr[p]] = 1'b0;
      for (int i = 0; i < 2; i++)
         if (a[i] && s[i].rdv && s[i].rd != 0) mb[s[i].rd] = 1'b1;
      if (fl) foreach (mb[r]) mb[r] = 1'b0;
      miv = a;
      for (int i = 0; i < 2; i++)
         if (a[i]) begin
            mu[i] = s[i].unit;
            mr[i] = s[i].rd;
         end
   endtask

   task automatic cycle();
      bit [1:0] ea;
      #1;
      ea = m_accept();
      last_acc = dec_accept_o;
      chk("accept", dec_accept_o, ea);
      @(posedge clk);
      m_update(ea);
      #1;
      chk("iss_valid", iss_valid_o, miv);
      chk("iss_unit", iss_unit_o, {mu[1], mu[0]});
      chk("iss_rd", iss_rd_o, {mr[1], mr[0]});
      chk("busy", dut.busy_q, mbv());
      chk("stall_cnt", sb_stall_cnt_o, mcnt);
      @(negedge clk);
   endtask

   function automatic slot_t mk(bit [5:0] u, bit rdv, bit [4:0] rd,
                                bit r1v, bit [4:0] rs1,
                                bit r2v, bit [4:0] rs2);
      slot_t t;
      t.v = 1'b1; t.unit = u;
      t.rdv = rdv; t.rd = rd;
      t.r1v = r1v; t.rs1 = rs1;
      t.r2v = r2v; t.rs2 = rs2;
      return t;
   endfunction

   task automatic idle();
      s[0] = '{default: 0};
      s[1] = '{default: 0};
      wbv = 0; wbr[0] = 0; wbr[1] = 0;
      ubusy = 0; fl = 0;
   endtask

   task automatic wb1(bit [4:0] r);
      idle();
      wbv = 2'b01; wbr[0] = r;
      cycle();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      s[0] = mk(ALU, 1, 1, 1, 2, 0, 0);
      s[1] = mk(LSU, 1, 3, 0, 0, 1, 4);
      wbv = 2'b11; wbr[0] = 1; wbr[1] = 3; fl = 1;
      @(negedge clk);
      cycle();
      chk("rst_accept", last_acc, 2'b00);
      cycle();
      chk("rst_iss", iss_valid_o, 2'b00);
      chk("rst_busy", dut.busy_q, 32'h0);
      chk("rst_cnt", sb_stall_cnt_o, 32'h0);
      rst = 1'b0;
      idle();

      // dual ALU
      s[0] = mk(ALU, 1, 1, 1, 2, 1, 3);
      s[1] = mk(ALU, 1, 4, 1, 5, 1, 6);
      cycle();
      chk("dual_acc", last_acc, 2'b11);
      chk("dual_iss", iss_valid_o, 2'b11);
      chk("dual_busy", {dut.busy_q[4], dut.busy_q[1]}, 2'b11);
      idle(); wbv = 2'b11; wbr[0] = 1; wbr[1] = 4;
      cycle();

      // intra-pair RAW then writeback bypass
      idle();
      s[0] = mk(ALU, 1, 5, 1, 1, 1, 2);
      s[1] = mk(ALU, 1, 6, 1, 5, 0, 0);
      cycle();
      chk("raw_pair", last_acc, 2'b01);
      s[0] = s[1]; s[1] = '{default: 0};
      cycle();
      chk("raw_hold", last_acc, 2'b00);
      cycle();
      wbv = 2'b01; wbr[0] = 5;
      cycle();
      chk("raw_wb", last_acc, 2'b01);
      wb1(6);

      // structural
      s[0] = mk(LSU, 1, 8, 1, 9, 0, 0);
      s[1] = mk(LSU, 1, 10, 1, 11, 0, 0);
      cycle();
      chk("lsu_pair", last_acc, 2'b01);
      idle();
      wbv = 2'b01; wbr[0] = 8;
      ubusy = LSU;
      s[0] = mk(LSU, 1, 12, 1, 13, 0, 0);
      c0 = mcnt;
      cycle();
      chk("unit_busy", last_acc, 2'b00);
      chk("unit_nocnt", sb_stall_cnt_o, c0);

      // stall counting and saturation
      idle();
      s[0] = mk(ALU, 1, 7, 0, 0, 0, 0);
      cycle();
      s[0] = mk(ALU, 1, 20, 1, 7, 0, 0);
      c0 = mcnt;
      for (int k = 0; k < 10; k++) cycle();
      chk("stall10", sb_stall_cnt_o, c0 + 32'd10);
      dut.stall_cnt_q = 32'hFFFF_FFFD;
      mcnt = 32'hFFFF_FFFD;
      for (int k = 0; k < 4; k++) cycle();
      chk("stall_sat", sb_stall_cnt_o, 32'hFFFF_FFFF);
      wb1(7);

      // flush
      s[0] = mk(ALU, 1, 1, 0, 0, 0, 0);
      s[1] = mk(ALU, 1, 9, 0, 0, 0, 0);
      cycle();
      s[0] = mk(ALU, 1, 2, 1, 3, 0, 0);
      s[1] = mk(LSU, 1, 11, 0, 0, 0, 0);
      fl = 1;
      cycle();
      chk("flush_acc", last_acc, 2'b00);
      chk("flush_busy", dut.busy_q, 32'h0);
      chk("flush_iss", iss_valid_o, 2'b00);

      // set beats clear; x0 never busy
      idle();
      s[0] = mk(ALU, 1, 3, 0, 0, 0, 0);
      wbv = 2'b01; wbr[0] = 3;
      cycle();
      chk("race_set", dut.busy_q[3], 1'b1);
      idle();
      s[0] = mk(ALU, 1, 0, 0, 0, 0, 0);
      cycle();
      chk("x0_acc", last_acc, 2'b01);
      chk("x0_busy", dut.busy_q[0], 1'b0);
      wb1(3);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 2; i++) begin
            s[i].v    = $urandom_range(0, 3) != 0;
            s[i].unit = 6'(1) << $urandom_range(0, 5);
            s[i].rd   = 5'($urandom_range(0, 7));
            s[i].rs1  = 5'($urandom_range(0, 7));
            s[i].rs2  = 5'($urandom_range(0, 7));
            s[i].rdv  = 1'($urandom_range(0, 1));
            s[i].r1v  = 1'($urandom_range(0, 1));
            s[i].r2v  = 1'($urandom_range(0, 1));
            wbv[i]    = 1'($urandom_range(0, 1));
            wbr[i]    = 5'($urandom_range(0, 7));
         end
         ubusy = ($urandom_range(0, 3) == 0) ?
                 6'(1) << $urandom_range(0, 5) : 6'd0;
         fl  = $urandom_range(0, 19) == 0;
         rst = $urandom_range(0, 99) == 0;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
